aes_spi_sched: RTL

Transaction scheduler in front of the SPI_Main master driving the AES_Encrypt slave. Owns the AES key, shares the single SPI link between two block requesters with round-robin arbitration, and sequences each link transaction: key load, start pulse, wait for done, capture the result. Any key change causes a key-load transaction before the next block transaction. Each response returns the ciphertext tagged with the requester id.

---
 rtl/aes_spi_pkg.sv | 31 +++
 rtl/rr_arb2.sv | 17 +
 rtl/aes_spi_sched.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/aes_spi_pkg.sv
// Purpose: shared constants, state encoding and arbitration helper for the AES SPI scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_spi_pkg;

    localparam int AES_DATA_W  = 128;
    localparam int AES_TIMEOUT = 4095;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_KEY_GO   = 3'd1,
        ST_KEY_WAIT = 3'd2,
        ST_BLK_GO   = 3'd3,
        ST_BLK_WAIT = 3'd4,
        ST_RSP      = 3'd5
    } sched_state_e;

    // Two-way round robin: a lone requester always wins, on a tie the one
    // that did not win last time goes next.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
        logic [1:0] gnt;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Purpose: two-requester round-robin arbiter producing a one-hot grant.
// Latency: combinational, 0 cycles.
// Backpressure: none; the caller decides whether the grant is taken.
module rr_arb2
    import aes_spi_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // Grant selection is purely a function of who is asking and who won last.
    always_comb begin
        gnt_o = rr_pick(req_i, last_i);
    end

endmodule

// File: rtl/aes_spi_sched.sv
// Purpose: owns the AES key and sequences key-load / block transfers over one SPI link for two requesters.
// Latency: grant->spi_start 1 cycle; spi_done rising edge->rsp_valid 1 cycle; timeout after TIMEOUT wait cycles.
// Backpressure: rsp_valid holds until rsp_ready; key and requests are only accepted while idle.
module aes_spi_sched
    import aes_spi_pkg::*;
#(
    parameter int DATA_W  = AES_DATA_W,
    parameter int TIMEOUT = AES_TIMEOUT
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid,
    input  logic [DATA_W-1:0]   key_data,
    output logic                key_ready,
    input  logic [1:0]          req_valid,
    input  logic [2*DATA_W-1:0] req_data,
    output logic [1:0]          req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_error,
    output logic                spi_start,
    output logic [DATA_W-1:0]   spi_tx,
    input  logic [DATA_W-1:0]   spi_rx,
    input  logic                spi_done
);

    localparam int                CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    sched_state_e      state_q, state_d;
    logic [DATA_W-1:0] key_reg_q, key_reg_d;
    logic              key_dirty_q, key_dirty_d;
    logic              key_have_q, key_have_d;
    logic              rr_last_q, rr_last_d;
    logic              grant_id_q, grant_id_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] blk_q, blk_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_error_q, rsp_error_d;
    // Registered copy of "state is IDLE": keeps key_ready/req_ready low while in reset.
    logic              idle_q, idle_d;
    logic              done_q;

    logic [1:0]        gnt;
    logic              accept_key;
    logic              accept_req;
    logic              done_rise;
    logic              wait_hit;

    rr_arb2 u_arb (
        .req_i  (req_valid),
        .last_i (rr_last_q),
        .gnt_o  (gnt)
    );

    assign accept_key = idle_q & key_valid;
    assign accept_req = idle_q & ~key_valid & (|gnt);
    assign done_rise  = spi_done & ~done_q;
    assign wait_hit   = (wait_cnt_q == CNT_MAX);

    assign key_ready  = idle_q;
    assign req_ready  = accept_req ? gnt : 2'b00;
    assign rsp_valid  = (state_q == ST_RSP);
    assign rsp_id     = grant_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_error  = rsp_error_q;
    assign spi_start  = (state_q == ST_KEY_GO) || (state_q == ST_BLK_GO);

    // Transmit word is held for the whole GO/WAIT span so SPI_Main sees a stable value.
    always_comb begin
        spi_tx = '0;
        case (state_q)
            ST_KEY_GO, ST_KEY_WAIT: spi_tx = key_reg_q;
            ST_BLK_GO, ST_BLK_WAIT: spi_tx = blk_q;
            default:                spi_tx = '0;
        endcase
    end

    // Next-state logic: key bookkeeping, arbitration capture, wait timer and response capture.
    always_comb begin
        state_d     = state_q;
        key_reg_d   = key_reg_q;
        key_dirty_d = key_dirty_q;
        key_have_d  = key_have_q;
        rr_last_d   = rr_last_q;
        grant_id_d  = grant_id_q;
        wait_cnt_d  = wait_cnt_q;
        blk_d       = blk_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_key) begin
                    // Key write wins over requests; a later write simply overwrites.
                    key_reg_d   = key_data;
                    key_dirty_d = 1'b1;
                end else if (accept_req) begin
                    blk_d      = gnt[1] ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
                    grant_id_d = gnt[1];
                    rr_last_d  = gnt[1];
                    if (!key_have_q && !key_dirty_q) begin
                        rsp_error_d = 1'b1;
                        rsp_data_d  = '0;
                        state_d     = ST_RSP;
                    end else if (key_dirty_q) begin
                        state_d = ST_KEY_GO;
                    end else begin
                        state_d = ST_BLK_GO;
                    end
                end
            end
            ST_KEY_GO: begin
                wait_cnt_d = '0;
                state_d    = ST_KEY_WAIT;
            end
            ST_KEY_WAIT: begin
                if (done_rise) begin
                    key_dirty_d = 1'b0;
                    key_have_d  = 1'b1;
                    state_d     = ST_BLK_GO;
                end else if (wait_hit) begin
                    // Link state is unknown after a timeout: force a key resend next time.
                    key_have_d  = 1'b0;
                    key_dirty_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_data_d  = '0;
                    state_d     = ST_RSP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_BLK_GO: begin
                wait_cnt_d = '0;
                state_d    = ST_BLK_WAIT;
            end
            ST_BLK_WAIT: begin
                if (done_rise) begin
                    rsp_data_d  = spi_rx;
                    rsp_error_d = 1'b0;
                    state_d     = ST_RSP;
                end else if (wait_hit) begin
                    key_have_d  = 1'b0;
                    key_dirty_d = 1'b1;
                    rsp_error_d = 1'b1;
                    rsp_data_d  = '0;
                    state_d     = ST_RSP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign idle_d = (state_d == ST_IDLE);

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            key_reg_q   <= '0;
            key_dirty_q <= 1'b0;
            key_have_q  <= 1'b0;
            rr_last_q   <= 1'b1;
            grant_id_q  <= 1'b0;
            wait_cnt_q  <= '0;
            blk_q       <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
            idle_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_reg_q   <= key_reg_d;
            key_dirty_q <= key_dirty_d;
            key_have_q  <= key_have_d;
            rr_last_q   <= rr_last_d;
            grant_id_q  <= grant_id_d;
            wait_cnt_q  <= wait_cnt_d;
            blk_q       <= blk_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
            idle_q      <= idle_d;
            done_q      <= spi_done;
        end
    end

endmodule
